sd_data_rx: RTL and testbench
=============================

Name: sd_data_rx

Overview:
- Downstream of the CMD17 read sequencer, on the SD SPI MISO line.
- After the sequencer has seen the R1 response, this block hunts for the 0xFE start token and deserializes the 512-byte data block MSB-first.
- It streams the data out as bytes, then captures the trailing 16-bit CRC and checks it against a CRC16-CCITT computed locally.
- It reports done, crc_ok or timeout to the sequencer and any consumer, for example a buffer or UART bridge.

Parameters:
- BLOCK_BYTES, 512, data bytes per block; fixes the byte-address width to 9 bits at the default.
- TOKEN_TIMEOUT, 1024, maximum SD_CK cycles spent in WAIT_TOKEN before giving up; must be at least 1.

Ports:
- SD_CK  input  1  SPI clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- SD_MISO  input  1  serial data from the card.
- start  input  1  one-cycle pulse: R1 accepted, begin token hunt.
- abort  input  1  synchronous return to IDLE, dropping the current block.
- busy  output  1  high in any state except IDLE.
- data_o  output  8  last completed byte.
- data_valid  output  1  one-cycle strobe that qualifies data_o.
- byte_addr  output  9  index (0..511) of the byte currently on data_o.
- done  output  1  one-cycle pulse when a block ends (success, CRC error or timeout).
- crc_ok  output  1  result of the last block; held until the next accepted start.
- timeout  output  1  token not seen; held until the next accepted start.

Behaviour:
- Clock and reset: one clock, SD_CK. Reset is asynchronous and active-low on rst_n. All state changes on posedge SD_CK.
- Reset values: state=IDLE; busy, data_o, data_valid, byte_addr, done, crc_ok and timeout all 0; CRC register 0; shift register 8'hFF.
- IDLE:
  - start=1 → WAIT_TOKEN. On the same edge: clear crc_ok and timeout, load the timeout counter with TOKEN_TIMEOUT, set the shift register to 8'hFF, clear the CRC register.
  - start while busy is ignored.
- WAIT_TOKEN:
  - Each edge shifts SD_MISO into an 8-bit register (sh <= {sh[6:0], MISO}).
  - If {sh[6:0], MISO} == 8'hFE → DATA, with the bit counter at 0. The token bits do not enter the CRC.
  - Otherwise decrement the timeout counter. When it reaches 0 → DONE with timeout=1 and crc_ok=0.
  - A token detected on the same edge the counter expires wins.
- DATA:
  - 8*BLOCK_BYTES sampling edges. Every bit feeds the serial CRC16 (poly 0x1021, init 0x0000, MSB-first, no final XOR).
  - On the edge that samples the 8th bit of byte n: data_o = completed byte, byte_addr = n, data_valid = 1 for exactly one cycle.
  - After the 4096th bit → CRC.
- CRC:
  - 16 edges shift the received CRC in, MSB first. These bits are not fed to the CRC generator.
  - After the 16th edge → DONE, with crc_ok = (received == computed).
- DONE: done=1 for one cycle, then IDLE. crc_ok and timeout stay stable until the next accepted start.
- abort: overrides everything in any busy state. Next state is IDLE; data_valid and done are not asserted; crc_ok and timeout stay 0.
- Latency: the first data_valid appears 8 edges after the edge that completes the token. done appears 16 edges after the last data_valid, plus 1 edge (the DONE state).
- Width rules:
  - Bit counter is 12 bits, with no wrap inside a block.
  - byte_addr holds its last value (511) after the block ends.
  - Timeout counter is sized with $clog2(TOKEN_TIMEOUT+1).

Decomposition:
- Shared package sd_pkg, holding:
  - START_TOKEN = 8'hFE
  - CRC16_POLY = 16'h1021
  - BLOCK_BYTES default
  - the state encoding constants (IDLE, WAIT_TOKEN, DATA, CRC, DONE).
- One sub-module, sd_crc16: serial CRC16-CCITT.
  - Ports: SD_CK, rst_n, clr, en, din, crc[15:0].
  - Reused later by the write path.

Test Plan:
- Block of all 0xFF: start, 20 idle 1s, then 0xFE, 512 × 0xFF, CRC 0x7FA1 → 512 data_valid pulses, each with data_o=0xFF, byte_addr 0..511; then done=1, crc_ok=1, timeout=0.
- Incrementing pattern: data byte n = n[7:0], followed by the correct CRC computed by the bench model → bytes 0x00..0xFF repeated twice, crc_ok=1.
- Corrupted CRC: the all-0xFF block with CRC 0x7FA0 → all 512 bytes delivered, done=1, crc_ok=0.
- Token timeout: start with MISO held at 1 for 1024 cycles → done at cycle 1025, timeout=1, crc_ok=0, no data_valid.
- Abort mid-block: abort asserted after byte 100 → busy drops next cycle, no further data_valid, no done. A new start plus a good block afterwards gives crc_ok=1.
- Reset mid-DATA: rst_n pulsed low → all outputs go to 0 immediately. start is ignored while busy, and an extra start pulse during DATA does not restart the block.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD SPI data path.
package sd_pkg;

    localparam logic [7:0]  START_TOKEN    = 8'hFE;
    localparam logic [15:0] CRC16_POLY     = 16'h1021;
    localparam int          SD_BLOCK_BYTES = 512;

    // Receive FSM state encoding, also exported for debug observation.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_TOKEN = 3'd1,
        DATA       = 3'd2,
        CRC        = 3'd3,
        DONE       = 3'd4
    } sd_state_e;

endpackage

// File: rtl/sd_data_rx_if.sv
// Control and data bundle between the read sequencer / consumer and sd_data_rx.
//
// Handshake: start is a one-cycle request that is only honoured while busy is
// low. data_valid is a one-cycle strobe qualifying data_o/byte_addr; there is
// no back-pressure, so the consumer must take every strobed byte. done is a
// one-cycle strobe; crc_ok and timeout are levels held until the next start.
interface sd_data_rx_if #(
    parameter int ADDR_W = 9
);
    import sd_pkg::*;

    logic              SD_MISO;
    logic              start;
    logic              abort;
    logic              busy;
    logic [7:0]        data_o;
    logic              data_valid;
    logic [ADDR_W-1:0] byte_addr;
    logic              done;
    logic              crc_ok;
    logic              timeout;
    sd_state_e         state;

    modport master (
        output SD_MISO, start, abort,
        input  busy, data_o, data_valid, byte_addr, done, crc_ok, timeout, state
    );

    modport slave (
        input  SD_MISO, start, abort,
        output busy, data_o, data_valid, byte_addr, done, crc_ok, timeout, state
    );

endinterface

// File: rtl/sd_crc16.sv
// Serial CRC16-CCITT (poly 0x1021, init 0, MSB first, no final XOR).
module sd_crc16
    import sd_pkg::*;
(
    input  logic        SD_CK,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[15] ^ din;

    // One message bit per enabled edge; clr takes priority over en.
    always_ff @(posedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_data_rx.sv
// SD SPI read-data receiver: token hunt, 512-byte deserialize, CRC16 check.
module sd_data_rx
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES   = SD_BLOCK_BYTES,
    parameter int TOKEN_TIMEOUT = 1024
) (
    input logic         SD_CK,
    input logic         rst_n,
    sd_data_rx_if.slave bus
);

    localparam int ADDR_W = $clog2(BLOCK_BYTES);
    localparam int BIT_W  = $clog2(8 * BLOCK_BYTES);
    localparam int TW     = $clog2(TOKEN_TIMEOUT + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(8 * BLOCK_BYTES - 1);

    sd_state_e         state_q, state_n;
    logic [7:0]        sh_q, sh_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic [TW-1:0]     tcnt_q, tcnt_n;
    logic [15:0]       rxcrc_q, rxcrc_n;
    logic [7:0]        data_q, data_n;
    logic              dv_q, dv_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              done_q, done_n;
    logic              ok_q, ok_n;
    logic              to_q, to_n;
    logic              crc_clr, crc_en;
    logic [15:0]       crc_calc;
    logic [7:0]        sh_next;

    assign sh_next = {sh_q[6:0], bus.SD_MISO};

    sd_crc16 u_crc (
        .SD_CK (SD_CK),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (bus.SD_MISO),
        .crc   (crc_calc)
    );

    // Register all FSM and datapath state.
    always_ff @(posedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= 8'hFF;
            bit_q   <= '0;
            tcnt_q  <= '0;
            rxcrc_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            sh_q    <= sh_n;
            bit_q   <= bit_n;
            tcnt_q  <= tcnt_n;
            rxcrc_q <= rxcrc_n;
            data_q  <= data_n;
            dv_q    <= dv_n;
            addr_q  <= addr_n;
            done_q  <= done_n;
            ok_q    <= ok_n;
            to_q    <= to_n;
        end
    end

    // Next-state and datapath updates; abort overrides any busy state last.
    always_comb begin
        state_n = state_q;
        sh_n    = sh_q;
        bit_n   = bit_q;
        tcnt_n  = tcnt_q;
        rxcrc_n = rxcrc_q;
        data_n  = data_q;
        dv_n    = 1'b0;
        addr_n  = addr_q;
        done_n  = 1'b0;
        ok_n    = ok_q;
        to_n    = to_q;
        crc_clr = 1'b0;
        crc_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = WAIT_TOKEN;
                    ok_n    = 1'b0;
                    to_n    = 1'b0;
                    tcnt_n  = TW'(TOKEN_TIMEOUT);
                    sh_n    = 8'hFF;
                    crc_clr = 1'b1;
                end
            end
            WAIT_TOKEN: begin
                sh_n = sh_next;
                // A token on the expiry edge still wins.
                if (sh_next == START_TOKEN) begin
                    state_n = DATA;
                    bit_n   = '0;
                end else begin
                    tcnt_n = tcnt_q - TW'(1);
                    if (tcnt_q == TW'(1)) begin
                        state_n = DONE;
                        to_n    = 1'b1;
                        ok_n    = 1'b0;
                    end
                end
            end
            DATA: begin
                sh_n   = sh_next;
                crc_en = 1'b1;
                bit_n  = bit_q + BIT_W'(1);
                if (bit_q[2:0] == 3'd7) begin
                    data_n = sh_next;
                    dv_n   = 1'b1;
                    addr_n = bit_q[BIT_W-1:3];
                end
                if (bit_q == LAST_BIT) begin
                    state_n = CRC;
                    bit_n   = '0;
                end
            end
            CRC: begin
                rxcrc_n = {rxcrc_q[14:0], bus.SD_MISO};
                bit_n   = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(15)) begin
                    ok_n    = (rxcrc_n == crc_calc);
                    state_n = DONE;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (bus.abort && state_q != IDLE) begin
            state_n = IDLE;
            dv_n    = 1'b0;
            done_n  = 1'b0;
            data_n  = data_q;
            addr_n  = addr_q;
            ok_n    = ok_q;
            to_n    = to_q;
            crc_en  = 1'b0;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.data_o     = data_q;
    assign bus.data_valid = dv_q;
    assign bus.byte_addr  = addr_q;
    assign bus.done       = done_q;
    assign bus.crc_ok     = ok_q;
    assign bus.timeout    = to_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_sd_data_rx.sv
// Bench for sd_data_rx: directed SPI block streams with a queued scoreboard.
module tb_sd_data_rx;
    import sd_pkg::*;

    logic clk;
    logic rst_n;

    sd_data_rx_if #(.ADDR_W(9)) bus ();

    sd_data_rx #(.BLOCK_BYTES(512), .TOKEN_TIMEOUT(1024)) dut (
        .SD_CK (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [16:0] exp_q[$];       // {byte_addr, data_o}
    logic [1:0]  exp_done_q[$];  // {crc_ok, timeout}

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes an output.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_data_valid: got addr %0d data %h, required no strobe",
                             bus.byte_addr, bus.data_o);
                end else begin
                    chk("data_byte", 32'({bus.byte_addr, bus.data_o}), 32'(exp_q.pop_front()));
                end
            end
            if (bus.done) begin
                if (exp_done_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_done: got crc_ok %b timeout %b, required no done",
                             bus.crc_ok, bus.timeout);
                end else begin
                    chk("done_status", 32'({bus.crc_ok, bus.timeout}), 32'(exp_done_q.pop_front()));
                end
            end
        end
    end

    function automatic logic [7:0] byte_of(input int kind, input int n);
        logic [7:0] b;
        b = n[7:0];
        return (kind == 0) ? 8'hFF : b;
    endfunction

    // Byte-wise XModem CRC over the block contents.
    function automatic logic [15:0] crc_model(input int kind);
        logic [15:0] c;
        c = 16'h0000;
        for (int n = 0; n < 512; n++) begin
            c = c ^ {byte_of(kind, n), 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Drivers: each bit is held for one sampling posedge, changed on negedge.
    task automatic send_bit(input logic b);
        bus.SD_MISO = b;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pulse_start);
        for (int i = 7; i >= 0; i--) begin
            bus.start = pulse_start && (i == 7);
            send_bit(b[i]);
        end
        bus.start = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        bus.SD_MISO = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_token();
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        send_byte(START_TOKEN, 1'b0);
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL done_wait: got no done in %0d cycles, required done", max_cyc);
        end
    endtask

    task automatic run_block(input int kind, input logic [15:0] crc_v, input logic exp_ok);
        int n;
        exp_done_q.push_back({exp_ok, 1'b0});
        do_start();
        send_token();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back({9'(i), byte_of(kind, i)});
            send_byte(byte_of(kind, i), 1'b0);
        end
        send_byte(crc_v[15:8], 1'b0);
        send_byte(crc_v[7:0], 1'b0);
        bus.SD_MISO = 1'b1;
        wait_done(40, n);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [7:0] b;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.SD_MISO = 1'b1;

        // Reset state
        #12;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_crc_ok", 32'(bus.crc_ok), 32'h0);
        chk("rst_timeout", 32'(bus.timeout), 32'h0);
        chk("rst_state", 32'(bus.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // All-0xFF block with its known-good CRC
        run_block(0, 16'h7FA1, 1'b1);
        repeat (5) @(negedge clk);
        chk("ff_addr_hold", 32'(bus.byte_addr), 32'd511);
        chk("ff_crc_ok_hold", 32'(bus.crc_ok), 32'h1);
        chk("ff_busy_after", 32'(bus.busy), 32'h0);

        // Token timeout: MISO idle high
        exp_done_q.push_back(2'b01);
        do_start();
        chk("to_crc_ok_cleared", 32'(bus.crc_ok), 32'h0);
        bus.SD_MISO = 1'b1;
        wait_done(1100, n);
        chk("to_done_cycle", 32'(n), 32'd1025);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("to_timeout_hold", 32'(bus.timeout), 32'h1);

        // Incrementing pattern with model CRC
        run_block(1, crc_model(1), 1'b1);
        chk("inc_timeout_cleared", 32'(bus.timeout), 32'h0);

        // Corrupted CRC
        run_block(0, 16'h7FA0, 1'b0);

        // Abort after byte 100
        do_start();
        send_token();
        for (int i = 0; i <= 100; i++) begin
            b = 8'(i * 3 + 7);
            exp_q.push_back({9'(i), b});
            send_byte(b, 1'b0);
        end
        bus.abort = 1'b1;
        send_bit(1'b0);
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_crc_ok", 32'(bus.crc_ok), 32'h0);
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
        bus.SD_MISO = 1'b1;
        run_block(0, 16'h7FA1, 1'b1);

        // Extra start during DATA, then reset mid-block
        do_start();
        send_token();
        for (int i = 0; i < 50; i++) begin
            b = 8'(i) ^ 8'h5A;
            exp_q.push_back({9'(i), b});
            send_byte(b, i == 31);
            if (i == 31) begin
                chk("restart_busy", 32'(bus.busy), 32'h1);
                chk("restart_state", 32'(bus.state), 32'(DATA));
            end
        end
        chk("pre_rst_data", 32'(bus.data_o), 32'(8'd49 ^ 8'h5A));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_data_o", 32'(bus.data_o), 32'h0);
        chk("mid_rst_addr", 32'(bus.byte_addr), 32'h0);
        chk("mid_rst_dv", 32'(bus.data_valid), 32'h0);
        chk("mid_rst_state", 32'(bus.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_block(1, crc_model(1), 1'b1);

        repeat (5) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("exp_done_drained", 32'(exp_done_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
